// File: rtl/sound_sched_if.sv
// Producer-side handshake bundle for sound_sched: two 32-bit sample sources.
// master = producer side, slave = scheduler side.
interface sound_sched_if;
    logic        s0_valid;
    logic [31:0] s0_data;
    logic        s0_ready;
    logic        s1_valid;
    logic [31:0] s1_data;
    logic        s1_ready;

    modport master (output s0_valid, s0_data, s1_valid, s1_data,
                    input  s0_ready, s1_ready);
    modport slave  (input  s0_valid, s0_data, s1_valid, s1_data,
                    output s0_ready, s1_ready);
endinterface

// File: rtl/sound_sched.sv
// Frame scheduler + round-robin two-source arbiter feeding the PWM audio stage.
// Define SOUND_SCHED_REPEAT_EN to hold the previous word on underrun instead of playing silence.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | output muted, frame counter parked at 0, waiting for enable+prime
// ST_PLAY | word in data_o being played; reload on each frame counter wrap
module sound_sched #(
    parameter int          FIFO_DEPTH   = 4,
    parameter int          PRIME_LEVEL  = 2,
    parameter int          FRAME_CYCLES = 1024,
    parameter logic [31:0] SILENCE_WORD = 32'h8080_8080,
    localparam int         LW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    sound_sched_if.slave       prod,
    output logic               aud_en,
    output logic [31:0]        data_o,
    output logic               frame_start,
    output logic               underrun,
    output logic [LW-1:0]      level
);
    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam int            CW       = $clog2(FRAME_CYCLES);
    localparam logic [LW-1:0] PRIME_LV = LW'(PRIME_LEVEL);
    localparam logic [LW-1:0] FULL_LV  = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_CYCLES - 1);

    typedef enum logic {ST_IDLE, ST_PLAY} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     data_q, data_d;
    logic            aud_en_q, aud_en_d;
    logic            fs_q, fs_d;
    logic            underrun_q, underrun_d;
    logic            last_grant_q;
    logic [LW-1:0]   level_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [31:0]     mem [FIFO_DEPTH];

    logic            full, empty, gnt0, gnt1, xfer0, xfer1, push, pop;
    logic [31:0]     push_data, head;

    // last_grant_q: 1 means s1 won last, so s0 takes the next tie
    assign full  = (level_q == FULL_LV);
    assign empty = (level_q == '0);
    assign gnt0  = prod.s0_valid & (~prod.s1_valid | last_grant_q);
    assign gnt1  = prod.s1_valid & (~prod.s0_valid | ~last_grant_q);
    assign prod.s0_ready = gnt0 & ~full;
    assign prod.s1_ready = gnt1 & ~full;
    assign xfer0     = prod.s0_valid & prod.s0_ready;
    assign xfer1     = prod.s1_valid & prod.s1_ready;
    assign push      = xfer0 | xfer1;
    assign push_data = xfer1 ? prod.s1_data : prod.s0_data;
    assign head      = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            last_grant_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_q     <= wr_ptr_q + AW'(1);
                last_grant_q <= xfer1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            aud_en_q   <= 1'b0;
            fs_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            aud_en_q   <= aud_en_d;
            fs_q       <= fs_d;
            underrun_q <= underrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        aud_en_d   = aud_en_q;
        fs_d       = 1'b0;
        underrun_d = underrun_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d    = '0;
                aud_en_d = 1'b0;
                data_d   = '0;
                if (enable && (level_q >= PRIME_LV)) begin
                    pop        = 1'b1;
                    data_d     = head;
                    aud_en_d   = 1'b1;
                    fs_d       = 1'b1;
                    underrun_d = 1'b0;
                    state_d    = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    // a stop request only takes effect here, so the frame always completes
                    if (!enable) begin
                        state_d  = ST_IDLE;
                        aud_en_d = 1'b0;
                        data_d   = '0;
                    end else begin
                        fs_d = 1'b1;
                        if (!empty) begin
                            pop    = 1'b1;
                            data_d = head;
                        end else begin
                            underrun_d = 1'b1;
`ifdef SOUND_SCHED_REPEAT_EN
                            data_d = data_q;
`else
                            data_d = SILENCE_WORD;
`endif
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign aud_en      = aud_en_q;
    assign data_o      = data_q;
    assign frame_start = fs_q;
    assign underrun    = underrun_q;
    assign level       = level_q;
endmodule

// File: tb/tb_sound_sched.sv
// Directed bench for sound_sched: priming, frame timing, underrun, stop, arbitration, full FIFO, reset.
// Expected underrun word follows SOUND_SCHED_REPEAT_EN when the bench is built with it.
module tb_sound_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        aud_en;
    logic [31:0] data_o;
    logic        frame_start;
    logic        underrun;
    logic [2:0]  level;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_ur;

    sound_sched_if bus ();

    sound_sched dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .prod        (bus.slave),
        .aud_en      (aud_en),
        .data_o      (data_o),
        .frame_start (frame_start),
        .underrun    (underrun),
        .level       (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [31:0] w);
        bus.s0_valid = 1'b1;
        bus.s0_data  = w;
        #1;
        check("push0_ready", {31'b0, bus.s0_ready}, 32'd1);
        check("push0_s1_ready", {31'b0, bus.s1_ready}, 32'd0);
        @(posedge clk);
        #1;
        bus.s0_valid = 1'b0;
    endtask

    initial begin
`ifdef SOUND_SCHED_REPEAT_EN
        exp_ur = 32'h5566_7788;
`else
        exp_ur = 32'h8080_8080;
`endif
        rst = 1'b1;
        enable = 1'b0;
        bus.s0_valid = 1'b0;
        bus.s0_data  = '0;
        bus.s1_valid = 1'b0;
        bus.s1_data  = '0;
        #23;
        check("rst_aud_en", {31'b0, aud_en}, 32'd0);
        check("rst_data", data_o, 32'd0);
        check("rst_fs", {31'b0, frame_start}, 32'd0);
        check("rst_underrun", {31'b0, underrun}, 32'd0);
        check("rst_level", {29'b0, level}, 32'd0);
        rst = 1'b0;
        cyc(1);

        // prime, with a one-word level not sufficient to start
        push0(32'h1122_3344);
        check("level_1", {29'b0, level}, 32'd1);
        enable = 1'b1;
        cyc(1);
        check("prime_hold", {31'b0, aud_en}, 32'd0);
        enable = 1'b0;
        push0(32'h5566_7788);
        check("level_2", {29'b0, level}, 32'd2);
        enable = 1'b1;
        cyc(1);
        check("start_aud_en", {31'b0, aud_en}, 32'd1);
        check("start_data", data_o, 32'h1122_3344);
        check("start_fs", {31'b0, frame_start}, 32'd1);
        check("start_level", {29'b0, level}, 32'd1);
        cyc(1);
        check("fs_pulse_end", {31'b0, frame_start}, 32'd0);
        cyc(1022);
        check("f1_last_data", data_o, 32'h1122_3344);
        check("f1_last_fs", {31'b0, frame_start}, 32'd0);
        cyc(1);
        check("f2_data", data_o, 32'h5566_7788);
        check("f2_fs", {31'b0, frame_start}, 32'd1);
        check("f2_level", {29'b0, level}, 32'd0);
        check("f2_underrun", {31'b0, underrun}, 32'd0);
        cyc(1023);
        check("f2_last_fs", {31'b0, frame_start}, 32'd0);
        cyc(1);
        check("f3_data", data_o, exp_ur);
        check("f3_underrun", {31'b0, underrun}, 32'd1);
        check("f3_fs", {31'b0, frame_start}, 32'd1);
        check("f3_aud_en", {31'b0, aud_en}, 32'd1);

        // drop enable mid-frame; frame must complete
        cyc(500);
        enable = 1'b0;
        cyc(523);
        check("stop_last_aud_en", {31'b0, aud_en}, 32'd1);
        check("stop_last_data", data_o, exp_ur);
        cyc(1);
        check("stop_aud_en", {31'b0, aud_en}, 32'd0);
        check("stop_data", data_o, 32'd0);
        check("stop_fs", {31'b0, frame_start}, 32'd0);
        check("stop_underrun_sticky", {31'b0, underrun}, 32'd1);

        #2 rst = 1'b1;
        #2 rst = 1'b0;
        cyc(1);

        // round-robin with both producers valid, filling the FIFO
        bus.s0_valid = 1'b1;
        bus.s1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.s0_data = 32'hA000_0000 + i;
            bus.s1_data = 32'hB000_0000 + i;
            #1;
            check("rr_s0_ready", {31'b0, bus.s0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_s1_ready", {31'b0, bus.s1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
            @(posedge clk);
            #1;
        end
        check("full_level", {29'b0, level}, 32'd4);
        #1;
        check("full_s0_ready", {31'b0, bus.s0_ready}, 32'd0);
        check("full_s1_ready", {31'b0, bus.s1_ready}, 32'd0);
        cyc(1);
        check("full_no_fifth", {29'b0, level}, 32'd4);
        enable = 1'b1;
        cyc(1);
        check("rr_start_aud_en", {31'b0, aud_en}, 32'd1);
        check("rr_first_word", data_o, 32'hA000_0000);
        check("rr_start_level", {29'b0, level}, 32'd3);
        check("rr_after_pop_s0", {31'b0, bus.s0_ready}, 32'd1);
        bus.s0_valid = 1'b0;
        bus.s1_valid = 1'b0;
        cyc(1023);
        cyc(1);
        check("rr_second_word", data_o, 32'hB000_0001);
        check("rr_second_fs", {31'b0, frame_start}, 32'd1);
        check("rr_second_level", {29'b0, level}, 32'd2);

        // asynchronous reset mid-frame
        cyc(300);
        #2 rst = 1'b1;
        #1;
        check("arst_aud_en", {31'b0, aud_en}, 32'd0);
        check("arst_data", data_o, 32'd0);
        check("arst_fs", {31'b0, frame_start}, 32'd0);
        check("arst_underrun", {31'b0, underrun}, 32'd0);
        check("arst_level", {29'b0, level}, 32'd0);
        rst = 1'b0;
        cyc(2);
        check("arst_fifo_discarded", {29'b0, level}, 32'd0);
        check("arst_no_restart", {31'b0, aud_en}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sound_sched.md
# sound_sched

Frame scheduler and two-source arbiter in front of the PWM audio output stage. Two sample producers push 32-bit words (four 8-bit duty samples, MSB byte played first) through a round-robin arbiter into a small FIFO. The block drives the PWM stage's `aud_en` and 32-bit duty word, changing the word only on 1024-cycle frame boundaries so that every word is played in full.

## Interface
- `FIFO_DEPTH`, 4: FIFO entries; power of 2, at least 2.
- `PRIME_LEVEL`, 2: FIFO level required before playback starts; 1..`FIFO_DEPTH`.
- `FRAME_CYCLES`, 1024: cycles per word. Must equal the PWM stage's 4 slots × 256.
- `SILENCE_WORD`, 32'h8080_8080: word played on underrun (50% duty, no repeat).

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: playback request, level-sensitive.
- `s0_valid` in 1 / `s0_data` in 32 / `s0_ready` out 1: producer 0.
- `s1_valid` in 1 / `s1_data` in 32 / `s1_ready` out 1: producer 1.
- `aud_en` out 1: registered; connects to PWM `aud_en`.
- `data_o` out 32: registered; connects to PWM `data_i`.
- `frame_start` out 1: one-cycle pulse in the first cycle of each frame.
- `underrun` out 1: sticky flag; a frame boundary found the FIFO empty.
- `level` out clog2(`FIFO_DEPTH`)+1: current FIFO occupancy.

## Operation
- Reset values: `aud_en`=0, `data_o`=0, `frame_start`=0, `underrun`=0, `level`=0. State is IDLE, frame counter is 0, last_grant is s1, so s0 wins the first tie.
- Arbiter, combinational:
  - Only one requester valid: it is granted.
  - Both valid: the one not in last_grant is granted.
  - `sX_ready` = grant_X & !full, where `full` is derived from the registered `level`.
  - A transfer occurs on valid & ready. last_grant updates only on a transfer.
  - The non-granted ready is 0.
- FIFO:
  - Push on transfer; pop on frame load.
  - Simultaneous push and pop leaves `level` unchanged.
  - A pop on empty never occurs (underrun path).
  - A push while full never occurs because ready is 0.
- IDLE:
  - `aud_en`=0, `data_o`=0, frame counter held at 0.
  - When `enable` & `level`>=`PRIME_LEVEL`: pop the head into `data_o`, `aud_en`<=1, `frame_start`<=1, `underrun`<=0, go to PLAY.
- PLAY:
  - The frame counter increments every cycle.
  - At count `FRAME_CYCLES`-1, the counter goes to 0 and `frame_start`<=1. Then:
    - `enable`=0: go to IDLE, `aud_en`<=0, `data_o`<=0, no pop. `frame_start` stays 0 in this case.
    - `enable`=1 and FIFO non-empty: pop into `data_o`.
    - `enable`=1 and FIFO empty: underrun load (see Configuration), `underrun`<=1, stay in PLAY.
- Dropping `enable` mid-frame never truncates the current frame.
- Producers may push in any state; the FIFO is retained across IDLE.

## Timing
- The frame counter mirrors the PWM counter. The PWM counter is 0 in the first `aud_en`=1 cycle and counts with it. Therefore `data_o` changes only on the edge where the PWM counter wraps 1023→0.
- Start latency: the edge after `enable`=1 and `level`>=`PRIME_LEVEL` are both seen.
- Push-to-level latency is 1 cycle. `level` is registered.
- `frame_start` pulses are exactly `FRAME_CYCLES` apart during continuous PLAY.
- `rst` asserted mid-frame: all outputs clear immediately (asynchronously) and FIFO contents are discarded.

## Configuration
- `SOUND_SCHED_REPEAT_EN` defined: an underrun load re-plays the previous `data_o` word (holds it).
- Undefined: an underrun load writes `SILENCE_WORD`.
- `underrun` behaviour is identical in both builds.

## Test plan
- Prime and play: push 32'h11223344 and 32'h55667788 via s0, then set `enable`=1. Required: `aud_en` rises the next cycle with `data_o`=32'h11223344 and `frame_start`=1. After exactly 1024 cycles, `data_o`=32'h55667788.
- Round-robin: hold s0 and s1 valid continuously with FIFO draining. Required: grants alternate s0, s1, s0, …; the first tie after reset goes to s0; at most one ready is high per cycle.
- Full FIFO: 4 pushes with `enable`=0. Required: `level`=4, both readies 0, a fifth word is not accepted.
- Underrun: prime 2 words and play 3 frames. Required: in frame 3, `underrun`=1 and `data_o`=32'h80808080, or the frame-2 word when built with `SOUND_SCHED_REPEAT_EN`.
- Stop and reset: drop `enable` at frame cycle 500. Required: `aud_en` stays 1 until cycle 1023, then goes 0 with `data_o`=0. In a second run, assert `rst` mid-frame: all outputs read 0 immediately.
